// File: rtl/addr_conv_pipe.sv
// Converts hash-table candidate addresses to window-relative read address and match offset.
// Latency 2 (accept edge N, result visible after edge N+1, handshaken at N+2), throughput 1/cycle.
// Stalls whole pipe when out_valid && !out_ready; bubbles collapse. Optional stats: ADDR_CONV_STATS_EN.
module addr_conv_pipe #(
  parameter int ABS_W    = 32,
  parameter int WIN_W    = 16,
  parameter int MAX_DIST = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             head_ld,
  input  logic [ABS_W-1:0] head_in,
  input  logic             head_adv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ABS_W-1:0] cand_addr,
  input  logic [ABS_W-1:0] cur_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIN_W-1:0] relate_raddr,
  output logic [WIN_W-1:0] match_offset,
  output logic             outofrange,
  output logic [ABS_W-1:0] head_addr
`ifdef ADDR_CONV_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
`endif
);

  localparam logic [ABS_W-1:0] MAX_DIST_A = ABS_W'(MAX_DIST);

  logic             s1_vld;
  logic [ABS_W-1:0] s1_d_head;
  logic [ABS_W-1:0] s1_d_cur;
  logic             s2_vld;
  logic             pipe_adv;
  logic             accept;
  logic             oor_c;

  // Stage 2 drains or is empty: the whole pipe may move one step.
  assign pipe_adv  = !s2_vld || out_ready;
  assign in_ready  = pipe_adv;
  assign accept    = in_valid && pipe_adv;
  assign out_valid = s2_vld;

  // Candidate unusable: behind head / outside window, equal to cur, or too far back.
  always_comb begin
    oor_c = 1'b0;
    if ((|s1_d_head[ABS_W-1:WIN_W]) || (s1_d_cur == '0) || (s1_d_cur > MAX_DIST_A))
      oor_c = 1'b1;
  end

  // Window head register; load beats advance, both ignore pipeline stall.
  always_ff @(posedge clk) begin
    if (rst)
      head_addr <= '0;
    else if (head_ld)
      head_addr <= head_in;
    else if (head_adv)
      head_addr <= head_addr + 1'b1;
  end

  // Stage 1: modular differences against the pre-update head value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_d_head <= '0;
      s1_d_cur  <= '0;
    end else if (pipe_adv) begin
      s1_vld <= accept;
      if (accept) begin
        s1_d_head <= cand_addr - head_addr;
        s1_d_cur  <= cur_addr - cand_addr;
      end
    end
  end

  // Stage 2: range classification; outputs forced to zero when empty or out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld       <= 1'b0;
      relate_raddr <= '0;
      match_offset <= '0;
      outofrange   <= 1'b0;
    end else if (pipe_adv) begin
      s2_vld     <= s1_vld;
      outofrange <= s1_vld && oor_c;
      if (s1_vld && !oor_c) begin
        relate_raddr <= s1_d_head[WIN_W-1:0];
        match_offset <= s1_d_cur[WIN_W-1:0];
      end else begin
        relate_raddr <= '0;
        match_offset <= '0;
      end
    end
  end

`ifdef ADDR_CONV_STATS_EN
  logic out_hs;
  assign out_hs = s2_vld && out_ready;

  // Saturating hit/miss counters per delivered result; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (out_hs) begin
      if (outofrange) begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end else begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/addr_conv_pipe.md
ADDR_CONV_PIPE -- requirements
Module: addr_conv_pipe

Interface
REQ-001 SHALL have parameter ABS_W, default 32: absolute address width.
REQ-002 SHALL have parameter WIN_W, default 16: relative buffer address width; window = 2^WIN_W bytes.
REQ-003 SHALL have parameter MAX_DIST, default 65535: largest legal match offset; legal range 1..2^WIN_W-1.
REQ-004 SHALL have ports clk  input  1  single clock, all logic rising-edge; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports head_ld  input  1  load window head; head_in  input  ABS_W  new head value; head_adv  input  1  head += 1.
REQ-006 SHALL have ports in_valid  input  1; in_ready  output  1; cand_addr  input  ABS_W  candidate absolute address from hash table; cur_addr  input  ABS_W  current absolute input position.
REQ-007 SHALL have ports out_valid  output  1; out_ready  input  1; relate_raddr  output  WIN_W  buffer read address; match_offset  output  WIN_W  cur_addr-cand_addr; outofrange  output  1  candidate unusable.
REQ-008 SHALL have port head_addr  output  ABS_W  current head register value.

Function
REQ-009 SHALL accept a request when in_valid and in_ready are both high, and present a result when out_valid and out_ready are both high.
REQ-010 SHALL be a 2-stage pipeline: a request accepted at edge N is presented at edge N+2 when no stall occurs (latency 2, throughput 1/cycle).
REQ-011 SHALL stall the whole pipeline when out_valid=1 and out_ready=0; in_ready = !out_valid || out_ready, combinational from out_ready only.
REQ-012 SHALL hold relate_raddr, match_offset, outofrange stable while out_valid=1 and out_ready=0.
REQ-013 SHALL in stage 1 register d_head = cand_addr-head_addr and d_cur = cur_addr-cand_addr, both modulo 2^ABS_W, using the head value before any same-cycle head update.
REQ-014 SHALL in stage 2 set outofrange=1 if d_head > 2^WIN_W-1, or d_cur = 0, or d_cur > MAX_DIST (covers cand_addr behind head, ahead of cur_addr, and too far back, including wrap-around).
REQ-015 SHALL drive relate_raddr = d_head[WIN_W-1:0] and match_offset = d_cur[WIN_W-1:0] when outofrange=0, and both 0 when outofrange=1.
REQ-016 SHALL update head: head_ld gives head_in; else head_adv gives head+1 modulo 2^ABS_W; head_ld has priority when both high; updates occur regardless of stall.
REQ-017 SHALL let bubbles collapse: a stage-1 entry advances into an empty stage 2 even while out_ready=0.
REQ-018 SHALL drive out_valid=0 and outputs 0 whenever no result is held; no result is ever dropped or duplicated.

Reset
REQ-019 SHALL on rst=1 clear both stage valid bits, head_addr, relate_raddr, match_offset, outofrange to 0, and out_valid to 0 in the following cycle.
REQ-020 SHALL discard in-flight requests on rst mid-operation; rst has priority over head_ld/head_adv and handshakes.
REQ-021 SHALL hold in_ready=1 during and after reset (out_valid=0).

Configuration
REQ-022 SHALL, with macro ADDR_CONV_STATS_EN defined, add ports stats_clr  input  1; hit_cnt  output  16; miss_cnt  output  16.
REQ-023 SHALL with ADDR_CONV_STATS_EN increment hit_cnt (outofrange=0) or miss_cnt (outofrange=1) on each output handshake, saturating at 16'hFFFF, cleared by rst or stats_clr (clear wins over increment).
REQ-024 SHALL without ADDR_CONV_STATS_EN omit those ports and counters; all other behaviour identical.

Verification
REQ-025 SHALL cover: head=0x1000, cand=0x1234, cur=0x1300, out_ready=1 -> 2 cycles later out_valid=1, relate_raddr=0x0234, match_offset=0x00CC, outofrange=0.
REQ-026 SHALL cover: head=0x1000, cand=0x0FFF -> outofrange=1, relate_raddr=0, match_offset=0; cand=0x11000 -> outofrange=1 (d_head=0x10000).
REQ-027 SHALL cover: cand=cur=0x2000 -> outofrange=1; head=0xFFFFFFF0, cand=0x00000005, cur=0x00000010 -> relate_raddr=0x0015, match_offset=0x000B, outofrange=0.
REQ-028 SHALL cover: 8 back-to-back requests with out_ready toggling 1,0,0,1 pattern -> 8 results in order, values stable during stall, in_ready=0 exactly while out_valid=1 and out_ready=0.
REQ-029 SHALL cover: head_ld=1 (0x5000) and head_adv=1 same cycle as an accept with head=0x4000 -> accepted request uses 0x4000, head_addr=0x5000 next cycle; rst asserted with 2 in flight -> out_valid=0, no result appears.
REQ-030 SHALL cover (ADDR_CONV_STATS_EN): 3 hits, 2 misses -> hit_cnt=3, miss_cnt=2; stats_clr same cycle as a hit -> both 0.
